demux_router: RTL
=================

# demux_router

Packet-level steering controller in front of the 1:4 `demux`. It accepts a byte stream over a valid/ready handshake, decodes a one-byte header carrying destination and payload length, and forwards the payload bytes to one of four output channels through a one-entry registered output buffer. The block sequences the demux select and enable so that the shared datapath serves one destination per packet, with back-pressure per channel.

## Interface
- `DATA_W`, 8: payload/header byte width; must be ≥ 6.
- `LEN_W`, 4: width of the header length field; maximum payload is 2^LEN_W−1 bytes.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in DATA_W: header or payload byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts `in_data` this cycle.
- `out_data` out DATA_W: buffered payload byte, shared by all channels.
- `out_valid0`..`out_valid3` out 1 each: per-channel valid; at most one is high.
- `out_ready0`..`out_ready3` in 1 each: per-channel ready.
- `out_last` out 1: the buffered byte is the final byte of its packet.
- `busy` out 1: state is PAYLOAD.
- `pkt_done` out 1: one-cycle pulse when a packet completes.

## Operation
- Header byte: bits [1:0] are `dest`; bits [LEN_W+1:2] are `len`. Remaining bits are ignored.
- State machine with two states:
  - IDLE: `in_ready`=1. A transfer (`in_valid`&`in_ready`) latches `dest_q`/`cnt_q`=`len`.
    - If `len`=0, the packet is header-only: the block stays in IDLE and pulses `pkt_done` the next cycle.
    - Otherwise, go to PAYLOAD.
  - PAYLOAD: `in_ready` = !`obuf_valid` | `out_ready[obuf_dest]`.
    - Each accepted byte loads the output buffer (`obuf_data`, `obuf_dest`=`dest_q`, `obuf_last`=(`cnt_q`==1)) and decrements `cnt_q`.
    - When the byte with `cnt_q`==1 is accepted, go to IDLE.
- Output buffer: `out_valid[obuf_dest]` = `obuf_valid`; all other channels are 0.
  - The buffer drains when `out_ready[obuf_dest]` is high.
  - Load and drain may occur in the same cycle; the buffer stays valid with the new byte.
- `pkt_done` pulses one cycle after the drain of an `obuf_last` byte, or after a `len`=0 header.
- Headers are accepted in IDLE even while the buffer still holds the previous packet's last byte. That byte keeps its own `obuf_dest`, so a new destination cannot corrupt it.
- `out_ready` of non-selected channels is ignored.
- `in_data` is ignored when `in_valid`=0.

## Timing
- Reset values: state IDLE; `obuf_valid`=0; all `out_valid*`=0; `out_data`=0; `out_last`=0; `busy`=0; `pkt_done`=0; `cnt_q`=0; `dest_q`=0. `in_ready`=1 after reset.
- Latency: a payload byte accepted at cycle k presents on its `out_valid` at cycle k+1.
- Throughput: one byte per cycle with the selected `out_ready` held high. The header costs one cycle per packet.
- Back-pressure: with `out_ready[dest]`=0, at most one byte is buffered. `in_ready` falls in the cycle after the buffer fills.
- `out_data`/`out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-packet: the next edge with `rst`=1 discards the buffered byte and remaining count and returns to IDLE. No `pkt_done` is produced.
- `cnt_q` is LEN_W bits and never wraps; it is decremented only when non-zero.

## Structure
- Package `demux_router_pkg`: state enum (IDLE, PAYLOAD), header field LSB/MSB constants, `DEST_W`=2.
- Sub-module: the existing `demux` (e, s, y0..y3), instantiated with e=`obuf_valid`, s=`obuf_dest`, driving `out_valid0`..`out_valid3`.
- The FSM, counter and output buffer live in `demux_router`.

## Test plan
- Reset, then send header 0x0E (dest 2, len 3) and payload 0xA1, 0xA2, 0xA3, all ready high:
  - `out_valid2` high for 3 consecutive cycles with data A1, A2, A3.
  - `out_last` on A3; `pkt_done` one cycle after A3 drains.
- Header 0x05 (dest 1, len 1), byte 0x55, with `out_ready1` low for 5 cycles:
  - `out_valid1` holds 0x55 stable for 5 cycles.
  - A second header plus byte: the header is accepted, but the byte stalls (`in_ready`=0 in PAYLOAD) until the drain.
- Back-to-back packets, dest 3 len 1 then dest 0 len 2, with `out_ready3` low:
  - The dest-0 header is accepted while the dest-3 byte is pending.
  - The dest-3 byte still exits on `out_valid3`, never on `out_valid0`.
- Header 0x00 (len 0): no `out_valid*` activity; `pkt_done` pulses once; `busy` stays 0.
- Assert `rst` after 2 of 4 payload bytes:
  - All outputs return to reset values on the next edge.
  - A fresh packet then routes correctly; no `pkt_done` for the aborted packet.
- Maximum length 15 with random `out_ready` toggling:
  - Exactly 15 bytes are delivered, in order.
  - `out_valid` is one-hot or zero every cycle.

Source files
------------

// File: rtl/demux_router_pkg.sv
// ---------------------------------------------------------------
// demux_router_pkg : shared types and header field positions
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package demux_router_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam int DEST_W   = 2;
  localparam int DEST_LSB = 0;
  localparam int DEST_MSB = DEST_LSB + DEST_W - 1;
  localparam int LEN_LSB  = DEST_MSB + 1;

  // The length field sits directly above dest; its top bit depends on LEN_W.
  function automatic int len_msb(input int len_w);
    return LEN_LSB + len_w - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux.sv
// ---------------------------------------------------------------
// demux : 1:4 enable demultiplexer, one-hot output when e is high
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module demux (
  input  logic       e,
  input  logic [1:0] s,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3
);

  assign y0 = e & (s == 2'd0);
  assign y1 = e & (s == 2'd1);
  assign y2 = e & (s == 2'd2);
  assign y3 = e & (s == 2'd3);

endmodule

`default_nettype wire

// File: rtl/demux_router.sv
// ---------------------------------------------------------------
// demux_router : header-decoded packet steering onto a 1:4 demux
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module demux_router
  import demux_router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid0,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic              out_valid3,
  input  logic              out_ready0,
  input  logic              out_ready1,
  input  logic              out_ready2,
  input  logic              out_ready3,
  output logic              out_last,
  output logic              busy,
  output logic              pkt_done
);

  localparam int LEN_MSB = len_msb(LEN_W);

  state_t              state_q;
  state_t              state_d;
  logic [DEST_W-1:0]   dest_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   obuf_data;
  logic [DEST_W-1:0]   obuf_dest;
  logic                obuf_valid;
  logic                obuf_last;

  logic [3:0]          out_ready_vec;
  logic                sel_ready;
  logic                drain;
  logic                accept;
  logic                hdr_accept;
  logic                pay_accept;
  logic                last_beat;
  logic [DEST_W-1:0]   hdr_dest;
  logic [LEN_W-1:0]    hdr_len;

  assign out_ready_vec = {out_ready3, out_ready2, out_ready1, out_ready0};
  // Only the channel owning the buffered byte may drain it.
  assign sel_ready     = out_ready_vec[obuf_dest];
  assign drain         = obuf_valid & sel_ready;

  assign hdr_dest      = in_data[DEST_MSB:DEST_LSB];
  assign hdr_len       = in_data[LEN_MSB:LEN_LSB];

  assign in_ready      = (state_q == IDLE) | ~obuf_valid | sel_ready;
  assign accept        = in_valid & in_ready;
  assign hdr_accept    = accept & (state_q == IDLE);
  assign pay_accept    = accept & (state_q == PAYLOAD);
  assign last_beat     = (cnt_q == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hdr_accept && (hdr_len != '0)) state_d = PAYLOAD;
      PAYLOAD: if (pay_accept && last_beat)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q     <= '0;
      cnt_q      <= '0;
      obuf_data  <= '0;
      obuf_dest  <= '0;
      obuf_valid <= 1'b0;
      obuf_last  <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      pkt_done <= (drain & obuf_last) | (hdr_accept & (hdr_len == '0));

      if (hdr_accept) begin
        dest_q <= hdr_dest;
        cnt_q  <= hdr_len;
      end else if (pay_accept && (cnt_q != '0)) begin
        cnt_q  <= cnt_q - LEN_W'(1);
      end

      // A load wins over a same-cycle drain: the buffer stays full with the new byte.
      if (pay_accept) begin
        obuf_valid <= 1'b1;
        obuf_data  <= in_data;
        obuf_dest  <= dest_q;
        obuf_last  <= last_beat;
      end else if (drain) begin
        obuf_valid <= 1'b0;
      end
    end
  end

  assign out_data = obuf_data;
  assign out_last = obuf_last;
  assign busy     = (state_q == PAYLOAD);

  demux u_demux (
    .e  (obuf_valid),
    .s  (obuf_dest),
    .y0 (out_valid0),
    .y1 (out_valid1),
    .y2 (out_valid2),
    .y3 (out_valid3)
  );

endmodule

`default_nettype wire
